// File: rtl/sisc_mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding,
// owner codes and default bus widths.
package sisc_mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb2_rr.sv
// Combinational two-way arbiter between the fetch (F) and data (D) paths.
// Fixed data priority or round-robin on ties, chosen by DATA_PRIO.
module arb2_rr
  import sisc_mem_pkg::*;
#(
  parameter int DATA_PRIO = 1
) (
  input  logic f_req,
  input  logic d_req,
  input  logic last_owner,
  output logic winner
);

  always_comb begin
    winner = OWN_F;
    if (f_req && d_req) begin
      // On a tie in round-robin mode the side that did not go last wins.
      winner = (DATA_PRIO != 0) ? OWN_D : ~last_owner;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-port memory between instruction fetch and data load/store:
// grant, one mem_en strobe, fixed latency wait, then a one-cycle ack.
module mem_arb
  import sisc_mem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MEM_LAT   = 1,
  parameter int DATA_PRIO = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cnt;
  logic          r_owner;
  logic          r_we;
  logic          r_f_ack;
  logic          r_d_ack;
  logic [DW-1:0] r_f_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_busy;

  logic w_f_req_m;
  logic w_d_req_m;
  logic w_winner;
  logic w_grant;
  logic w_done;

  // During the ack cycle the owner's request is ignored so the other side
  // can take the very next slot.
  assign w_f_req_m = f_req & ~((r_state == RESP) & (r_owner == OWN_F));
  assign w_d_req_m = d_req & ~((r_state == RESP) & (r_owner == OWN_D));

  arb2_rr #(
    .DATA_PRIO(DATA_PRIO)
  ) u_arb (
    .f_req     (w_f_req_m),
    .d_req     (w_d_req_m),
    .last_owner(r_owner),
    .winner    (w_winner)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        if (w_f_req_m || w_d_req_m) begin
          w_grant     = 1'b1;
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (r_cnt == LAT) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_cnt       <= '0;
      r_owner     <= OWN_D;
      r_we        <= 1'b0;
      r_f_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy   <= (w_state_nxt != IDLE);
      r_f_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;

      if (w_grant) begin
        r_owner  <= w_winner;
        r_cnt    <= '0;
        r_mem_en <= 1'b1;
        if (w_winner == OWN_D) begin
          r_we        <= d_we;
          r_mem_we    <= d_we;
          r_mem_addr  <= d_addr;
          r_mem_wdata <= d_wdata;
        end else begin
          r_we       <= 1'b0;
          r_mem_addr <= f_addr;
        end
      end else if ((r_state == ACCESS) && !w_done) begin
        r_cnt <= r_cnt + 3'd1;
      end

      if (w_done) begin
        if (r_owner == OWN_F) begin
          r_f_ack   <= 1'b1;
          r_f_rdata <= mem_rdata;
        end else begin
          r_d_ack <= 1'b1;
          if (!r_we) begin
            r_d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign f_ack     = r_f_ack;
  assign f_rdata   = r_f_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: four instances cover MEM_LAT 1/2/3 and both
// arbitration modes, each backed by a fixed-latency memory model.
module tb_mem_arb;

  localparam int N = 4;
  localparam int LAT_TAB  [N] = '{1, 2, 1, 3};
  localparam int PRIO_TAB [N] = '{1, 1, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_f     [N];
  logic        f_req     [N];
  logic [15:0] f_addr    [N];
  logic        f_ack     [N];
  logic [31:0] f_rdata   [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [15:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic        d_ack     [N];
  logic [31:0] d_rdata   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [15:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        busy      [N];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return {16'h8801, a - 16'd3};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [7:0]  r_en_sr = '0;
    logic [15:0] r_addr_sr [8];

    always @(posedge clk) begin
      r_en_sr      <= {r_en_sr[6:0], (mem_en[g] === 1'b1)};
      r_addr_sr[0] <= mem_addr[g];
      for (int k = 1; k < 8; k++) r_addr_sr[k] <= r_addr_sr[k-1];
    end

    // Data is valid only in the single cycle MEM_LAT after the strobe.
    assign mem_rdata[g] = r_en_sr[LAT_TAB[g]-1] ? mem_val(r_addr_sr[LAT_TAB[g]-1])
                                                 : 32'h0BAD0BAD;

    mem_arb #(
      .AW(16), .DW(32), .MEM_LAT(LAT_TAB[g]), .DATA_PRIO(PRIO_TAB[g])
    ) u_dut (
      .clk      (clk),
      .rst_f    (rst_f[g]),
      .f_req    (f_req[g]),
      .f_addr   (f_addr[g]),
      .f_ack    (f_ack[g]),
      .f_rdata  (f_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ack    (d_ack[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int g = 0; g < N; g++) begin
      rst_f[g] = 1'b0; f_req[g] = 1'b0; f_addr[g] = '0;
      d_req[g] = 1'b0; d_we[g] = 1'b0; d_addr[g] = '0; d_wdata[g] = '0;
    end
    repeat (2) tick();
    for (int g = 0; g < N; g++) begin
      checks++;
      if ({busy[g], mem_en[g], mem_we[g], f_ack[g], d_ack[g]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: busy/en/we/fack/dack=%b expected 00000", g,
                 {busy[g], mem_en[g], mem_we[g], f_ack[g], d_ack[g]});
      end
      checks++;
      if ({f_rdata[g], d_rdata[g], mem_addr[g], mem_wdata[g]} !== '0) begin
        errors++;
        $display("FAIL reset_data[%0d]: f_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h expected 0",
                 g, f_rdata[g], d_rdata[g], mem_addr[g], mem_wdata[g]);
      end
    end
    for (int g = 0; g < N; g++) rst_f[g] = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b mem_en=%b expected 0 0", busy[0], mem_en[0]);
    end
  endtask

  task automatic test_fetch();
    f_req[0] = 1'b1; f_addr[0] = 16'h0003;
    tick();  // T+1
    checks++;
    if (mem_en[0] !== 1'b1 || mem_addr[0] !== 16'h0003 || mem_we[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL fetch_issue: en=%b addr=%h we=%b busy=%b expected 1 0003 0 1",
               mem_en[0], mem_addr[0], mem_we[0], busy[0]);
    end
    tick();  // T+2
    checks++;
    if (mem_en[0] !== 1'b0 || f_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait: en=%b f_ack=%b expected 0 0", mem_en[0], f_ack[0]);
    end
    tick();  // T+3
    checks++;
    if (f_ack[0] !== 1'b1 || f_rdata[0] !== 32'h88010000) begin
      errors++;
      $display("FAIL fetch_ack: f_ack=%b f_rdata=%h expected 1 88010000", f_ack[0], f_rdata[0]);
    end
    checks++;
    if (d_ack[0] !== 1'b0 || mem_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_quiet: d_ack=%b mem_we=%b expected 0 0", d_ack[0], mem_we[0]);
    end
    f_req[0] = 1'b0;
    tick();
    checks++;
    if (f_ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse: f_ack=%b busy=%b expected 0 0", f_ack[0], busy[0]);
    end
  endtask

  task automatic test_write();
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 16'h0040; d_wdata[1] = 32'hDEADBEEF;
    tick();  // T+1
    checks++;
    if (mem_en[1] !== 1'b1 || mem_we[1] !== 1'b1 || mem_addr[1] !== 16'h0040 ||
        mem_wdata[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_issue: en=%b we=%b addr=%h wdata=%h expected 1 1 0040 deadbeef",
               mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1]);
    end
    d_addr[1] = 16'h0077; d_wdata[1] = 32'h12345678;
    tick();  // T+2
    checks++;
    if (mem_en[1] !== 1'b0 || mem_we[1] !== 1'b0 || mem_addr[1] !== 16'h0040 ||
        mem_wdata[1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_hold: en=%b we=%b addr=%h wdata=%h expected 0 0 0040 deadbeef",
               mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1]);
    end
    tick();  // T+3
    checks++;
    if (d_ack[1] !== 1'b0) begin
      errors++;
      $display("FAIL write_early_ack: d_ack=%b expected 0", d_ack[1]);
    end
    tick();  // T+4
    checks++;
    if (d_ack[1] !== 1'b1 || d_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL write_ack: d_ack=%b d_rdata=%h expected 1 00000000", d_ack[1], d_rdata[1]);
    end
    d_req[1] = 1'b0; d_we[1] = 1'b0;
    tick();
    checks++;
    if (d_ack[1] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse: d_ack=%b busy=%b expected 0 0", d_ack[1], busy[1]);
    end
  endtask

  task automatic test_addr_hold();
    f_req[0] = 1'b1; f_addr[0] = 16'h0005;
    tick();  // T+1
    f_addr[0] = 16'h0009;
    tick();  // T+2
    checks++;
    if (mem_addr[0] !== 16'h0005) begin
      errors++;
      $display("FAIL addr_hold: mem_addr=%h expected 0005", mem_addr[0]);
    end
    tick();  // T+3
    checks++;
    if (f_ack[0] !== 1'b1 || f_rdata[0] !== mem_val(16'h0005)) begin
      errors++;
      $display("FAIL addr_hold_data: f_ack=%b f_rdata=%h expected 1 %h",
               f_ack[0], f_rdata[0], mem_val(16'h0005));
    end
    f_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int en_c [2];
    logic [15:0] en_a [2];
    int n_en = 0;
    int d_c = 0;
    int f_c = 0;
    f_req[0] = 1'b1; f_addr[0] = 16'h0010;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0020;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_en[0] === 1'b1) begin
        if (n_en < 2) begin
          en_c[n_en] = c;
          en_a[n_en] = mem_addr[0];
        end
        n_en++;
      end
      if (d_ack[0] === 1'b1) begin
        d_c = c; d_req[0] = 1'b0;
      end
      if (f_ack[0] === 1'b1) begin
        f_c = c; f_req[0] = 1'b0;
      end
    end
    checks++;
    if (n_en != 2) begin
      errors++;
      $display("FAIL prio_en_count: saw %0d strobes expected 2", n_en);
    end else begin
      checks++;
      if (en_c[0] != 1 || en_a[0] !== 16'h0020 || en_c[1] != 4 || en_a[1] !== 16'h0010) begin
        errors++;
        $display("FAIL prio_order: strobes at %0d/%h and %0d/%h expected 1/0020 and 4/0010",
                 en_c[0], en_a[0], en_c[1], en_a[1]);
      end
    end
    checks++;
    if (d_c != 3 || f_c != 6) begin
      errors++;
      $display("FAIL prio_ack_timing: d_ack at %0d f_ack at %0d expected 3 and 6", d_c, f_c);
    end
    checks++;
    if (d_rdata[0] !== mem_val(16'h0020) || f_rdata[0] !== mem_val(16'h0010)) begin
      errors++;
      $display("FAIL prio_data: d_rdata=%h f_rdata=%h expected %h %h",
               d_rdata[0], f_rdata[0], mem_val(16'h0020), mem_val(16'h0010));
    end
  endtask

  task automatic test_round_robin();
    int exp_c [4] = '{3, 6, 9, 12};
    logic exp_d [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int ack_c [$];
    logic ack_d [$];
    int both = 0;
    f_req[2] = 1'b1; f_addr[2] = 16'h0100;
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 16'h0200;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (f_ack[2] === 1'b1 && d_ack[2] === 1'b1) both++;
      if (f_ack[2] === 1'b1) begin ack_c.push_back(c); ack_d.push_back(1'b0); end
      if (d_ack[2] === 1'b1) begin ack_c.push_back(c); ack_d.push_back(1'b1); end
      if (ack_c.size() == 4) begin
        f_req[2] = 1'b0; d_req[2] = 1'b0;
      end
    end
    checks++;
    if (ack_c.size() != 4 || both != 0) begin
      errors++;
      $display("FAIL rr_ack_count: saw %0d acks (%0d overlapping) expected 4 (0)", ack_c.size(), both);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_c[i] != exp_c[i] || ack_d[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL rr_grant%0d: ack at %0d owner_d=%b expected %0d owner_d=%b",
                   i, ack_c[i], ack_d[i], exp_c[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (f_rdata[2] !== mem_val(16'h0100) || d_rdata[2] !== mem_val(16'h0200) || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL rr_data: f_rdata=%h d_rdata=%h busy=%b expected %h %h 0",
               f_rdata[2], d_rdata[2], busy[2], mem_val(16'h0100), mem_val(16'h0200));
    end
  endtask

  task automatic test_reset_mid();
    int n_ack = 0;
    int en_c = 0;
    int ack_c = 0;
    f_req[3] = 1'b1; f_addr[3] = 16'h0030;
    tick();  // T+1
    checks++;
    if (mem_en[3] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_issue: mem_en=%b expected 1", mem_en[3]);
    end
    tick();  // T+2
    rst_f[3] = 1'b0; f_req[3] = 1'b0;
    tick();
    checks++;
    if (busy[3] !== 1'b0 || mem_en[3] !== 1'b0 || f_ack[3] !== 1'b0 || mem_addr[3] !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_state: busy=%b en=%b f_ack=%b addr=%h expected 0 0 0 0000",
               busy[3], mem_en[3], f_ack[3], mem_addr[3]);
    end
    rst_f[3] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (f_ack[3] === 1'b1 || d_ack[3] === 1'b1) n_ack++;
    end
    checks++;
    if (n_ack != 0) begin
      errors++;
      $display("FAIL rst_mid_no_ack: saw %0d acks expected 0", n_ack);
    end
    f_req[3] = 1'b1; f_addr[3] = 16'h0031;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (mem_en[3] === 1'b1 && en_c == 0) en_c = c;
      if (f_ack[3] === 1'b1 && ack_c == 0) begin
        ack_c = c; f_req[3] = 1'b0;
      end
    end
    checks++;
    if (en_c != 1 || ack_c != 5 || f_rdata[3] !== mem_val(16'h0031)) begin
      errors++;
      $display("FAIL rst_mid_recover: en at %0d ack at %0d f_rdata=%h expected 1 5 %h",
               en_c, ack_c, f_rdata[3], mem_val(16'h0031));
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_addr_hold();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter and sequencer that shares one single-port memory between two requesters.
- Requester F is the instruction-fetch path: the pc value feeds the ir load.
- Requester D is the data load/store path, driven by ctrl for LOD/STR-class instructions.
- The block grants one requester at a time, issues a single memory access, waits a fixed memory latency, then returns read data plus a one-cycle acknowledge to the owner.

Parameters:
AW, 16, address width (matches pc_out / br_addr)
DW, 32, data width (matches ir / register file)
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7
DATA_PRIO, 1, 1 = D wins every tie; 0 = round-robin between F and D

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  synchronous active-low reset
f_req  in  1  fetch request, held until f_ack
f_addr  in  AW  fetch address
f_ack  out  1  one-cycle pulse; f_rdata valid this cycle
f_rdata  out  DW  fetch read data, held until next F read completes
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_ack  out  1  one-cycle pulse; access complete, d_rdata valid on reads
d_rdata  out  DW  data read data, held until next D read completes
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-low on rst_f.
  - rst_f low at an edge forces: state IDLE, cnt 0, last_owner D, and every output 0 (acks, rdata, mem_*, busy).
- Registered outputs: all outputs come from flops; no combinational path from any input to any output.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Neither request high: stay in IDLE.
  - Any request high at edge T: pick owner, latch addr/we/wdata, go to ACCESS.
  - In cycle T+1: mem_en=1, mem_we = latched we (F is always a read), mem_addr/mem_wdata = latched values.
- Arbitration:
  - One request high: that requester wins.
  - Both high, DATA_PRIO=1: D wins.
  - Both high, DATA_PRIO=0: the requester that is not last_owner wins.
  - last_owner updates on every grant.
- ACCESS:
  - mem_en is high only in its first cycle.
  - cnt counts MEM_LAT cycles after the mem_en cycle.
  - At the edge ending cycle (mem_en cycle + MEM_LAT):
    - On a read, capture mem_rdata into the owner's rdata register.
    - Assert the owner's ack for the next cycle and go to RESP.
  - Result: request sampled at T gives ack in cycle T+2+MEM_LAT.
- RESP:
  - The ack cycle; ack is high for exactly one cycle.
  - The owner's req is ignored in this cycle; a requester must drop req, or re-request, after seeing ack.
  - The non-owner's req is arbitrated here exactly as in IDLE. If high, go straight to ACCESS with mem_en next cycle; otherwise go to IDLE.
- Writes:
  - d_rdata is unchanged on a write.
  - d_ack has the same timing as a read.
- Request and address rules:
  - Address and data are sampled only at the grant edge; later changes are ignored.
  - A req dropped before grant has no effect.
  - A req dropped after grant does not abort the access; the ack is still issued.
- mem_addr/mem_wdata/mem_we hold their last values between accesses; mem_we returns to 0 when mem_en is 0.
- cnt width is 3 bits; MEM_LAT never wraps it.
- Reset mid-operation: the access is abandoned with no ack; mem_en drops at the reset edge.

Decomposition:
- Package sisc_mem_pkg holds:
  - state encoding IDLE=2'b00, ACCESS=2'b01, RESP=2'b10;
  - owner constants OWN_F=1'b0, OWN_D=1'b1;
  - default widths AW/DW.
- Sub-module arb2_rr: combinational 2-way arbiter with inputs f_req, d_req, last_owner and DATA_PRIO, output winner. It is instantiated once and unit-tested separately.
- FSM, latency counter and output registers stay in mem_arb.

Test Plan:
- MEM_LAT=1; rst_f low for 2 cycles, then f_req=1, f_addr=16'h0003, mem_rdata=32'h88010000 -> mem_en=1 and mem_addr=0003 in T+1; f_ack pulse in T+3 with f_rdata=88010000; d_ack and mem_we stay 0.
- MEM_LAT=2; d_req=1, d_we=1, d_addr=16'h0040, d_wdata=32'hDEADBEEF -> one mem_en cycle with mem_we=1, mem_addr=0040, mem_wdata=DEADBEEF; d_ack in T+4; d_rdata unchanged at 0.
- DATA_PRIO=1; f_req and d_req rise together, both held -> D served first; F is granted in D's RESP cycle; f_ack exactly MEM_LAT+2 cycles after d_ack; mem_en never overlaps.
- DATA_PRIO=0; both requesters held continuously for 4 transactions -> grants alternate F,D,F,D (reset last_owner=D so F goes first); each ack is a one-cycle pulse.
- MEM_LAT=3; rst_f driven low in the cycle after mem_en -> next edge gives state IDLE, busy=0, no ack ever issued; a fresh f_req after reset completes normally.
- f_addr changed from 0005 to 0009 one cycle after grant -> mem_addr stays 0005; response data corresponds to 0005.
